clock_time_setter: RTL and testbench

- Upstream time-entry stage for the digital clock run counter.
- Debounces two raw push-buttons (mode, increment) and runs an edit FSM that steps through hour, minute and second fields, preloaded from the live time.
- On completion, presents hour_set/minute_set/second_set and issues a single-cycle set_en load pulse to the run counter.
- Also exports the active field for display blinking.

---
 rtl/clock_time_setter.sv | 180 ++++++++++++++++++
 tb/tb_clock_time_setter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clock_time_setter.sv
// Time-entry front end for the run counter: debounces the mode/inc buttons and
// walks hour/minute/second edit fields, ending in a one-cycle set_en load pulse.

module clock_time_setter_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // press is raised on the same edge the stable level rises, so it lines up
  // with the accepted level rather than lagging it by a further cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module clock_time_setter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic [5:0] hour_set,
  output logic [5:0] minute_set,
  output logic [5:0] second_set,
  output logic       set_en,
  output logic [1:0] edit_field
);

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MS_MAX   = 6'd59;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EDIT_H = 3'd1,
    EDIT_M = 3'd2,
    EDIT_S = 3'd3,
    LOAD   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [5:0] hour_next;
  logic [5:0] minute_next;
  logic [5:0] second_next;
  logic [1:0] field_next;
  logic       mode_press;
  logic       inc_press;

  clock_time_setter_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_mode (
    .clk  (clk),
    .rst_n(rst_n),
    .key  (key_mode),
    .press(mode_press)
  );

  clock_time_setter_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_inc (
    .clk  (clk),
    .rst_n(rst_n),
    .key  (key_inc),
    .press(inc_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hour_set   <= '0;
      minute_set <= '0;
      second_set <= '0;
      set_en     <= 1'b0;
      edit_field <= 2'd0;
    end else begin
      state      <= state_next;
      hour_set   <= hour_next;
      minute_set <= minute_next;
      second_set <= second_next;
      set_en     <= (state_next == LOAD);
      edit_field <= field_next;
    end
  end

  // mode is checked before inc in every edit state, so a simultaneous press
  // advances the field and the increment is dropped
  always_comb begin
    state_next  = state;
    hour_next   = hour_set;
    minute_next = minute_set;
    second_next = second_set;
    case (state)
      IDLE: begin
        if (mode_press) begin
          state_next  = EDIT_H;
          hour_next   = (cur_hour   > HOUR_MAX) ? 6'd0 : cur_hour;
          minute_next = (cur_minute > MS_MAX)   ? 6'd0 : cur_minute;
          second_next = (cur_second > MS_MAX)   ? 6'd0 : cur_second;
        end
      end
      EDIT_H: begin
        if (mode_press) begin
          state_next = EDIT_M;
        end else if (inc_press) begin
          hour_next = (hour_set >= HOUR_MAX) ? 6'd0 : hour_set + 6'd1;
        end
      end
      EDIT_M: begin
        if (mode_press) begin
          state_next = EDIT_S;
        end else if (inc_press) begin
          minute_next = (minute_set >= MS_MAX) ? 6'd0 : minute_set + 6'd1;
        end
      end
      EDIT_S: begin
        if (mode_press) begin
          state_next = LOAD;
        end else if (inc_press) begin
          second_next = (second_set >= MS_MAX) ? 6'd0 : second_set + 6'd1;
        end
      end
      LOAD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    field_next = 2'd0;
    case (state_next)
      EDIT_H:  field_next = 2'd1;
      EDIT_M:  field_next = 2'd2;
      EDIT_S:  field_next = 2'd3;
      default: field_next = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Directed bench for clock_time_setter with a short debounce window.

module tb_clock_time_setter;

  logic       clk;
  logic       rst_n;
  logic       key_mode;
  logic       key_inc;
  logic [5:0] cur_hour;
  logic [5:0] cur_minute;
  logic [5:0] cur_second;
  logic [5:0] hour_set;
  logic [5:0] minute_set;
  logic [5:0] second_set;
  logic       set_en;
  logic [1:0] edit_field;

  int checks   = 0;
  int failures = 0;
  int set_en_cnt = 0;

  clock_time_setter #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .cur_hour  (cur_hour),
    .cur_minute(cur_minute),
    .cur_second(cur_second),
    .hour_set  (hour_set),
    .minute_set(minute_set),
    .second_set(second_set),
    .set_en    (set_en),
    .edit_field(edit_field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (set_en) set_en_cnt++;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // hold the key(s) long enough to be accepted, then let the release settle
  task automatic press_keys(input logic m, input logic i);
    @(posedge clk); #1;
    key_mode = m;
    key_inc  = i;
    repeat (10) @(posedge clk);
    #1;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check_val({tag, "_hour"},   hour_set,   h);
    check_val({tag, "_minute"}, minute_set, m);
    check_val({tag, "_second"}, second_set, s);
  endtask

  initial begin
    rst_n      = 1'b0;
    key_mode   = 1'b0;
    key_inc    = 1'b0;
    cur_hour   = 6'd0;
    cur_minute = 6'd0;
    cur_second = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_field", edit_field, 0);
    check_val("reset_set_en", set_en, 0);
    check_time("reset", 0, 0, 0);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check_val("idle_no_set_en", set_en_cnt, 0);

    // glitch of 3 cycles must be rejected
    key_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    key_mode = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("glitch_field", edit_field, 0);

    // full edit 12:34:56 -> 15:36:56, with latency check on the first press
    cur_hour = 6'd12; cur_minute = 6'd34; cur_second = 6'd56;
    @(posedge clk); #1;
    key_mode = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_val("latency_6", edit_field, 0);
    @(posedge clk); #1;
    check_val("latency_7", edit_field, 1);
    repeat (3) @(posedge clk);
    #1;
    key_mode = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("one_press_field", edit_field, 1);
    check_time("capture", 12, 34, 56);
    cur_hour = 6'd3; cur_minute = 6'd3; cur_second = 6'd3;
    repeat (3) press_keys(1'b0, 1'b1);
    check_val("inc_hour", hour_set, 15);
    press_keys(1'b1, 1'b0);
    check_val("field_m", edit_field, 2);
    repeat (2) press_keys(1'b0, 1'b1);
    check_val("inc_minute", minute_set, 36);
    press_keys(1'b1, 1'b0);
    check_val("field_s", edit_field, 3);
    check_val("pre_load_set_en", set_en_cnt, 0);
    press_keys(1'b1, 1'b0);
    check_val("load_pulse", set_en_cnt, 1);
    check_val("load_field", edit_field, 0);
    check_time("load", 15, 36, 56);

    // wrap of every field
    cur_hour = 6'd23; cur_minute = 6'd59; cur_second = 6'd59;
    press_keys(1'b1, 1'b0);
    press_keys(1'b0, 1'b1);
    press_keys(1'b1, 1'b0);
    press_keys(1'b0, 1'b1);
    press_keys(1'b1, 1'b0);
    press_keys(1'b0, 1'b1);
    press_keys(1'b1, 1'b0);
    check_val("wrap_pulse", set_en_cnt, 2);
    check_time("wrap", 0, 0, 0);
    check_val("wrap_field", edit_field, 0);

    // out-of-range capture then simultaneous press
    cur_hour = 6'd40; cur_minute = 6'd7; cur_second = 6'd0;
    press_keys(1'b1, 1'b0);
    check_val("oor_hour", hour_set, 0);
    check_val("oor_minute", minute_set, 7);
    repeat (5) press_keys(1'b0, 1'b1);
    check_val("hour_5", hour_set, 5);
    press_keys(1'b1, 1'b1);
    check_val("simul_field", edit_field, 2);
    check_val("simul_hour", hour_set, 5);
    press_keys(1'b0, 1'b1);
    check_val("abort_pre_minute", minute_set, 8);

    // async reset mid-edit
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_field", edit_field, 0);
    check_time("abort", 0, 0, 0);
    check_val("abort_set_en", set_en, 0);
    #10;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_val("abort_no_pulse", set_en_cnt, 2);
    check_val("abort_idle", edit_field, 0);
    press_keys(1'b1, 1'b0);
    check_val("after_abort_field", edit_field, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
